// File: rtl/program_loader.sv
// Program loader: streams bytes from an external source into the CPU program RAM over the shared
// bus while holding the CPU clock, then pulses a CPU clear so execution restarts at address 0.
module program_loader #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  abort,
   input  logic                  byte_valid,
   input  logic [DATA_WIDTH-1:0] byte_data,
   output logic                  byte_ready,
   output logic [DATA_WIDTH-1:0] bus_out,
   output logic                  load_address,
   output logic                  ram_in,
   output logic                  cpu_hold,
   output logic                  cpu_clear,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [DATA_WIDTH-1:0] checksum
);

   localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StAddr,
      StWrite,
      StFinish
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
   logic                  aborted_q, aborted_d;

   logic                  bus_drive;
   logic [DATA_WIDTH-1:0] bus_val;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         remaining_q <= '0;
         data_q      <= '0;
         checksum_q  <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         data_q      <= data_d;
         checksum_q  <= checksum_d;
         aborted_q   <= aborted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      data_d      = data_q;
      checksum_d  = checksum_q;
      aborted_d   = aborted_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               // Zero length and anything past the RAM depth both mean "fill the whole RAM".
               if (length == '0 || length > Depth) begin
                  remaining_d = Depth;
               end else begin
                  remaining_d = length;
               end
               addr_d     = '0;
               checksum_d = '0;
               aborted_d  = 1'b0;
               state_d    = StWait;
            end
         end
         StWait: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = StIdle;
            end else if (byte_valid) begin
               data_d  = byte_data;
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = StIdle;
            end else begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            // The write strobe is already on the bus, so the byte counts even if aborted.
            checksum_d  = checksum_q + data_q;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = StIdle;
            end else if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
               state_d = StFinish;
            end else begin
               state_d = StWait;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      byte_ready   = 1'b0;
      load_address = 1'b0;
      ram_in       = 1'b0;
      cpu_hold     = 1'b0;
      cpu_clear    = 1'b0;
      done         = 1'b0;
      busy         = 1'b0;
      bus_drive    = 1'b0;
      bus_val      = '0;
      case (state_q)
         StWait: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            busy       = 1'b1;
         end
         StAddr: begin
            load_address = 1'b1;
            cpu_hold     = 1'b1;
            busy         = 1'b1;
            bus_drive    = 1'b1;
            bus_val      = DATA_WIDTH'(addr_q);
         end
         StWrite: begin
            ram_in    = 1'b1;
            cpu_hold  = 1'b1;
            busy      = 1'b1;
            bus_drive = 1'b1;
            bus_val   = data_q;
         end
         StFinish: begin
            cpu_hold  = 1'b1;
            cpu_clear = 1'b1;
            done      = 1'b1;
            busy      = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus_out  = bus_drive ? bus_val : {DATA_WIDTH{1'bz}};
   assign aborted  = aborted_q;
   assign checksum = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: models the MAR/RAM on the bus and checks strobes, timing,
// checksum, clamping, abort and asynchronous clear.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       clear;
   logic       start;
   logic [4:0] length;
   logic       abort;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic [7:0] bus_out;
   logic       load_address;
   logic       ram_in;
   logic       cpu_hold;
   logic       cpu_clear;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [7:0] checksum;

   int n_checks = 0;
   int n_errors = 0;

   program_loader #(
      .ADDR_WIDTH(4),
      .DATA_WIDTH(8)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .start       (start),
      .length      (length),
      .abort       (abort),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .bus_out     (bus_out),
      .load_address(load_address),
      .ram_in      (ram_in),
      .cpu_hold    (cpu_hold),
      .cpu_clear   (cpu_clear),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .checksum    (checksum)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus-side model of the memory address register and program RAM.
   logic [7:0] mar;
   logic [7:0] ram [16];
   logic [7:0] pat [32];
   int edge_cnt = 0;
   int start_edge = 0;
   int n_writes, n_done, n_clr, done_rel, bad_cc, bad_strobe, bp_bad;
   int wr_addr [32];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin
      if (load_address) mar = bus_out;
      if (ram_in) begin
         ram[mar[3:0]] = bus_out;
         if (n_writes < 32) wr_addr[n_writes] = int'(mar);
         n_writes++;
      end
      if (done) begin
         n_done++;
         done_rel = edge_cnt - start_edge;
      end
      if (cpu_clear) n_clr++;
      if (done !== cpu_clear) bad_cc++;
      if (!(load_address || ram_in) && bus_out !== 8'bzzzz_zzzz) bad_strobe++;
      if (byte_ready && (load_address || ram_in)) bad_strobe++;
      if (load_address && ram_in) bad_strobe++;
      if (!busy && cpu_hold) bad_strobe++;
   end

   task automatic reset_mon();
      n_writes   = 0;
      n_done     = 0;
      n_clr      = 0;
      done_rel   = -1;
      bad_cc     = 0;
      bad_strobe = 0;
      bp_bad     = 0;
      for (int i = 0; i < 16; i++) ram[i] = 8'hxx;
   endtask

   // Hold valid low for `gap` WAIT cycles, then present the byte until it is taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      @(negedge clk);
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         check_eq("ready_timeout", 32'(byte_ready), 32'd1);
         return;
      end
      repeat (gap) begin
         if (!byte_ready) bp_bad++;
         @(negedge clk);
      end
      if (!byte_ready) bp_bad++;
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input int len, input int n, input int gap,
                           input logic [7:0] exp_ck, input int exp_done);
      int t;
      int bad_addr;
      int bad_ram;
      reset_mon();
      @(posedge clk);
      #1;
      start      = 1'b1;
      length     = 5'(len);
      start_edge = edge_cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) send_byte(pat[i], gap);
      t = 0;
      while (n_done == 0 && t < 20) begin
         @(negedge clk);
         #1;
         t++;
      end
      @(negedge clk);
      #1;
      check_eq({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
      check_eq({tag, "_idle"}, 32'(busy), 32'd0);
      check_eq({tag, "_writes"}, 32'(n_writes), 32'(n));
      bad_addr = 0;
      bad_ram  = 0;
      for (int i = 0; i < n && i < 16; i++) begin
         if (wr_addr[i] != i) bad_addr++;
         if (ram[i] !== pat[i]) bad_ram++;
      end
      check_eq({tag, "_addr_seq"}, 32'(bad_addr), 32'd0);
      check_eq({tag, "_ram"}, 32'(bad_ram), 32'd0);
      check_eq({tag, "_checksum"}, 32'(checksum), 32'(exp_ck));
      check_eq({tag, "_done_cycle"}, 32'(done_rel), 32'(exp_done));
      check_eq({tag, "_done_count"}, 32'(n_done), 32'd1);
      check_eq({tag, "_clear_with_done"}, 32'(bad_cc), 32'd0);
      check_eq({tag, "_strobes"}, 32'(bad_strobe), 32'd0);
      check_eq({tag, "_ready_gap"}, 32'(bp_bad), 32'd0);
   endtask

   initial begin
      int k;
      int t;
      clear      = 1'b1;
      start      = 1'b0;
      length     = '0;
      abort      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = '0;
      mar        = '0;
      reset_mon();
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_bus_z", 32'(bus_out === 8'bzzzz_zzzz), 32'd1);
      check_eq("rst_strobes", {28'd0, byte_ready, load_address, ram_in, cpu_hold}, 32'd0);
      check_eq("rst_pulses", {30'd0, done, cpu_clear}, 32'd0);
      check_eq("rst_checksum", 32'(checksum), 32'd0);
      check_eq("rst_aborted", 32'(aborted), 32'd0);
      @(posedge clk);
      #1;
      clear = 1'b0;

      // 1E + 2F + E0 = 0x12D -> 0x2D
      pat[0] = 8'h1E; pat[1] = 8'h2F; pat[2] = 8'hE0;
      run_load("basic", 3, 3, 0, 8'h2D, 10);
      run_load("backpressure", 3, 3, 4, 8'h2D, 22);

      for (int i = 0; i < 16; i++) pat[i] = 8'(i);
      run_load("full", 0, 16, 0, 8'h78, 49);
      check_eq("full_addr_wrap", 32'(dut.addr_q), 32'd0);

      // sum(i + 5) for i = 0..15 = 200
      for (int i = 0; i < 16; i++) pat[i] = 8'(i + 5);
      run_load("clamp", 20, 16, 0, 8'hC8, 49);

      // Abort during the WRITE of the third byte (index 2).
      pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
      reset_mon();
      @(posedge clk);
      #1;
      start      = 1'b1;
      length     = 5'd4;
      byte_valid = 1'b1;
      byte_data  = pat[0];
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      t = 0;
      while (k < 3 && t < 100) begin
         @(negedge clk);
         t++;
         if (ram_in) begin
            k++;
            if (k == 3) abort = 1'b1;
            else byte_data = pat[k];
         end
      end
      check_eq("abort_reached", 32'(k), 32'd3);
      @(posedge clk);
      #1;
      abort      = 1'b0;
      byte_valid = 1'b0;
      @(negedge clk);
      #1;
      check_eq("abort_idle", 32'(busy), 32'd0);
      check_eq("abort_flag", 32'(aborted), 32'd1);
      check_eq("abort_hold_fell", 32'(cpu_hold), 32'd0);
      check_eq("abort_writes", 32'(n_writes), 32'd3);
      check_eq("abort_byte2", 32'(ram[2]), 32'h33);
      check_eq("abort_checksum", 32'(checksum), 32'h66);
      repeat (3) @(negedge clk);
      #1;
      check_eq("abort_no_done", 32'(n_done), 32'd0);
      check_eq("abort_no_clear", 32'(n_clr), 32'd0);

      pat[0] = 8'h5C;
      run_load("after_abort", 1, 1, 0, 8'h5C, 4);
      check_eq("after_abort_flag", 32'(aborted), 32'd0);

      // Asynchronous clear in the second ADDR cycle, with start held high while busy.
      pat[0] = 8'hA5; pat[1] = 8'h5A;
      reset_mon();
      @(posedge clk);
      #1;
      start      = 1'b1;
      length     = 5'd3;
      start_edge = edge_cnt;
      send_byte(pat[0], 0);
      send_byte(pat[1], 0);
      @(negedge clk);
      check_eq("rst_mid_in_addr", 32'(load_address), 32'd1);
      check_eq("rst_mid_start_ignored", 32'(bus_out), 32'd1);
      #2;
      clear = 1'b1;
      start = 1'b0;
      #1;
      check_eq("rst_mid_strobes", {30'd0, load_address, ram_in}, 32'd0);
      check_eq("rst_mid_bus_z", 32'(bus_out === 8'bzzzz_zzzz), 32'd1);
      check_eq("rst_mid_busy", 32'(busy), 32'd0);
      check_eq("rst_mid_checksum", 32'(checksum), 32'd0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_stays_idle", 32'(busy), 32'd0);
      check_eq("rst_mid_ram0", 32'(ram[0]), 32'hA5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
